// File: rtl/frame_reducer_pkg.sv
// Shared types and helpers for the frame_reducer datapath.
// Holds the per-chain mode encoding and the field extraction from the 8-bit mode word.
package frame_reducer_pkg;

    localparam int MODE_W = 2;
    localparam int CFG_W  = 8;

    typedef enum logic [MODE_W-1:0] {
        PASS = 2'd0,
        SUM  = 2'd1,
        MAX  = 2'd2,
        RSVD = 2'd3
    } mode_e;

    // Chain c owns bits [2c+1:2c] of the mode word.
    function automatic mode_e mode_of(input logic [CFG_W-1:0] word, input int unsigned chain);
        logic [CFG_W-1:0] shifted;
        shifted = word >> (MODE_W * chain);
        return mode_e'(shifted[MODE_W-1:0]);
    endfunction

    // RSVD deliberately falls back to pass-through behaviour.
    function automatic logic is_reducing(input mode_e mode);
        return (mode == SUM) || (mode == MAX);
    endfunction

endpackage

// File: rtl/frame_reducer_lane.sv
// One lane of the reduction: combines the running accumulator with the incoming
// element. Module name is reduce_lane; the top instantiates it once per lane.
module reduce_lane
    import frame_reducer_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  mode_e                 mode,
    input  logic                  bof,
    input  logic [DATA_WIDTH-1:0] acc,
    input  logic [DATA_WIDTH-1:0] v,
    output logic [DATA_WIDTH-1:0] next
);

    // A frame start ignores the stale accumulator; SUM wraps modulo 2^DATA_WIDTH.
    always_comb begin
        next = v;
        case (mode)
            SUM: begin
                if (!bof) begin
                    next = acc + v;
                end
            end
            MAX: begin
                if (!bof && ($signed(acc) > $signed(v))) begin
                    next = acc;
                end
            end
            default: begin
                next = v;
            end
        endcase
    end

endmodule

// File: rtl/frame_reducer.sv
// Per-chain frame reducer: pass-through, element-wise sum or signed max per frame,
// with a two-stage pipeline and one N-lane accumulator per chain.
module frame_reducer
    import frame_reducer_pkg::*;
#(
    parameter int          N                  = 8,
    parameter int          DATA_WIDTH         = 32,
    parameter int          MAX_CHAINS         = 4,
    parameter logic [7:0]  INITIAL_FIRMWARE   = 8'h00,
    parameter logic [7:0]  PERSONAL_CONFIG_ID = 8'h01,
    localparam int         CHAIN_W            = (MAX_CHAINS > 1) ? $clog2(MAX_CHAINS) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           tracing,
    input  logic [7:0]                     configId,
    input  logic [7:0]                     configData,
    input  logic                           valid_in,
    input  logic                           bof_in,
    input  logic                           eof_in,
    input  logic [CHAIN_W-1:0]             chainId_in,
    input  logic [N-1:0][DATA_WIDTH-1:0]   vector_in,
    output logic                           valid_out,
    output logic                           eof_out,
    output logic [CHAIN_W-1:0]             chainId_out,
    output logic [N-1:0][DATA_WIDTH-1:0]   vector_out
);

    logic [7:0]                     mode_reg;

    logic                           s1_valid;
    logic                           s1_bof;
    logic                           s1_eof;
    logic [CHAIN_W-1:0]             s1_chain;
    logic [N-1:0][DATA_WIDTH-1:0]   s1_vector;

    logic [N-1:0][DATA_WIDTH-1:0]   acc [MAX_CHAINS];
    logic [N-1:0][DATA_WIDTH-1:0]   acc_rd;
    logic [N-1:0][DATA_WIDTH-1:0]   lane_next;
    mode_e                          s1_mode;
    logic                           s1_live;

    assign s1_mode = mode_of(mode_reg, 32'(s1_chain));
    assign acc_rd  = acc[s1_chain];
    // A beat sitting in stage 1 when tracing drops is discarded, not processed.
    assign s1_live = s1_valid && tracing;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_lane
            reduce_lane #(
                .DATA_WIDTH (DATA_WIDTH)
            ) u_lane (
                .mode (s1_mode),
                .bof  (s1_bof),
                .acc  (acc_rd[gi]),
                .v    (s1_vector[gi]),
                .next (lane_next[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_reg    <= INITIAL_FIRMWARE;
            s1_valid    <= 1'b0;
            s1_bof      <= 1'b0;
            s1_eof      <= 1'b0;
            s1_chain    <= '0;
            s1_vector   <= '0;
            valid_out   <= 1'b0;
            eof_out     <= 1'b0;
            chainId_out <= '0;
            vector_out  <= '0;
            for (int c = 0; c < MAX_CHAINS; c++) begin
                acc[c] <= '0;
            end
        end else begin
            if (!tracing && (configId == PERSONAL_CONFIG_ID)) begin
                mode_reg <= configData;
            end

            // Stage 1: capture the beat only while processing the stream.
            if (tracing) begin
                s1_valid  <= valid_in;
                s1_bof    <= bof_in;
                s1_eof    <= eof_in;
                s1_chain  <= chainId_in;
                s1_vector <= vector_in;
            end else begin
                s1_valid  <= 1'b0;
            end

            // Stage 2: read-modify-write of the chain accumulator plus output select.
            valid_out <= 1'b0;
            if (s1_live) begin
                if (is_reducing(s1_mode)) begin
                    acc[s1_chain] <= lane_next;
                    if (s1_eof) begin
                        valid_out   <= 1'b1;
                        eof_out     <= 1'b1;
                        chainId_out <= s1_chain;
                        vector_out  <= lane_next;
                    end
                end else begin
                    valid_out   <= 1'b1;
                    eof_out     <= s1_eof;
                    chainId_out <= s1_chain;
                    vector_out  <= s1_vector;
                end
            end
        end
    end

endmodule

// File: tb/tb_frame_reducer.sv
// Directed and randomized checks of frame_reducer against a frame-level reference model.
module tb_frame_reducer;

    localparam int         N     = 8;
    localparam int         DW    = 32;
    localparam int         NC    = 4;
    localparam logic [7:0] MY_ID = 8'h01;

    typedef logic [N-1:0][DW-1:0] vec_t;
    typedef struct {
        int   due;
        int   ch;
        bit   eof;
        vec_t vec;
        bit   chk;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tracing = 1'b1;
    logic [7:0] configId = 8'h00;
    logic [7:0] configData = 8'h00;
    logic       valid_in = 1'b0;
    logic       bof_in = 1'b0;
    logic       eof_in = 1'b0;
    logic [1:0] chainId_in = 2'd0;
    vec_t       vector_in = '0;
    logic       valid_out;
    logic       eof_out;
    logic [1:0] chainId_out;
    vec_t       vector_out;

    int         checks = 0;
    int         errors = 0;
    int         pe = 0;

    exp_t       q[$];
    vec_t       acc_m [NC];
    bit         dirty [NC];
    logic [7:0] mode_m = 8'h00;
    vec_t       last_vec = '0;

    frame_reducer #(
        .N                  (N),
        .DATA_WIDTH         (DW),
        .MAX_CHAINS         (NC),
        .INITIAL_FIRMWARE   (8'h00),
        .PERSONAL_CONFIG_ID (MY_ID)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tracing     (tracing),
        .configId    (configId),
        .configData  (configData),
        .valid_in    (valid_in),
        .bof_in      (bof_in),
        .eof_in      (eof_in),
        .chainId_in  (chainId_in),
        .vector_in   (vector_in),
        .valid_out   (valid_out),
        .eof_out     (eof_out),
        .chainId_out (chainId_out),
        .vector_out  (vector_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) pe <= pe + 1;

    function automatic void cmp(input string name, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endfunction

    function automatic vec_t fill(input logic [31:0] x);
        vec_t f;
        for (int l = 0; l < N; l++) f[l] = x;
        return f;
    endfunction

    function automatic int chain_mode(input logic [7:0] w, input int ch);
        return (int'(w) >> (2 * ch)) & 3;
    endfunction

    // Reference: what a beat contributes to its chain, and what (if anything) it emits.
    function automatic void model_beat(input bit b, input bit e, input int ch, input vec_t d, input int due);
        int   m;
        vec_t nx;
        exp_t x;
        m = chain_mode(mode_m, ch);
        nx = '0;
        x.due = due;
        x.ch = ch;
        if (m == 1 || m == 2) begin
            for (int l = 0; l < N; l++) begin
                if (b) nx[l] = d[l];
                else if (m == 1) nx[l] = acc_m[ch][l] + d[l];
                else nx[l] = ($signed(acc_m[ch][l]) > $signed(d[l])) ? acc_m[ch][l] : d[l];
            end
            acc_m[ch] = nx;
            if (b) dirty[ch] = 1'b0;
            if (e) begin
                x.eof = 1'b1;
                x.vec = nx;
                x.chk = !dirty[ch];
                q.push_back(x);
            end
        end else begin
            x.eof = e;
            x.vec = d;
            x.chk = 1'b1;
            q.push_back(x);
        end
    endfunction

    task automatic drive(input bit v, input bit b, input bit e, input int ch, input vec_t d, input bit model = 1'b1);
        @(posedge clk);
        #1;
        valid_in   = v;
        bof_in     = b;
        eof_in     = e;
        chainId_in = 2'(ch);
        vector_in  = d;
        if (v && model) model_beat(b, e, ch, d, pe + 2);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0, 0, '0);
    endtask

    task automatic cfg(input logic [7:0] w, input logic [7:0] id);
        idle(3);
        @(posedge clk);
        #1;
        valid_in   = 1'b0;
        tracing    = 1'b0;
        configId   = id;
        configData = w;
        if (id == MY_ID) begin
            for (int c = 0; c < NC; c++)
                if (chain_mode(w, c) != chain_mode(mode_m, c)) dirty[c] = 1'b1;
            mode_m = w;
        end
        @(posedge clk);
        #1;
        tracing  = 1'b1;
        configId = 8'h00;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst      = 1'b1;
        valid_in = 1'b0;
        mode_m   = 8'h00;
        q.delete();
        for (int c = 0; c < NC; c++) begin
            acc_m[c] = '0;
            dirty[c] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Single compare process: every cycle, the output either matches the due expectation or is idle and held.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            cmp("rst_valid", 256'(valid_out), 256'(0));
            cmp("rst_vector", 256'(vector_out), 256'(0));
            last_vec = '0;
        end else begin
            while (q.size() > 0 && q[0].due < pe) begin
                e = q.pop_front();
                checks++;
                errors++;
                $display("FAIL missed_output: chain %0d due cycle %0d got no valid_out expected valid_out=1", e.ch, e.due);
            end
            if (q.size() > 0 && q[0].due == pe) begin
                e = q.pop_front();
                cmp("out_valid", 256'(valid_out), 256'(1));
                cmp("out_chain", 256'(chainId_out), 256'(e.ch));
                cmp("out_eof", 256'(eof_out), 256'(e.eof));
                if (e.chk) cmp("out_vector", 256'(vector_out), 256'(e.vec));
                last_vec = vector_out;
            end else begin
                cmp("idle_valid", 256'(valid_out), 256'(0));
                cmp("idle_hold", 256'(vector_out), 256'(last_vec));
            end
        end
    end

    initial begin
        vec_t v;
        for (int c = 0; c < NC; c++) begin
            acc_m[c] = '0;
            dirty[c] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Pass-through after reset: lane i = i+1.
        for (int l = 0; l < N; l++) v[l] = 32'(l + 1);
        for (int j = 0; j < 4; j++) drive(1'b1, j == 0, j == 3, 0, v);
        idle(3);
        cmp("lit_pass_lane7", 256'(vector_out[7]), 256'(8));
        cmp("lit_pass_eof", 256'(eof_out), 256'(1));

        // Chain 0 SUM: 5+5+5.
        cfg(8'h01, MY_ID);
        drive(1'b1, 1'b1, 1'b0, 0, fill(32'd5));
        drive(1'b1, 1'b0, 1'b0, 0, fill(32'd5));
        drive(1'b1, 1'b0, 1'b1, 0, fill(32'd5));
        idle(3);
        cmp("lit_sum15", 256'(vector_out[3]), 256'(15));

        // A second bof discards the open partial.
        drive(1'b1, 1'b1, 1'b0, 0, fill(32'd50));
        drive(1'b1, 1'b1, 1'b0, 0, fill(32'd6));
        drive(1'b1, 1'b0, 1'b1, 0, fill(32'd7));
        idle(3);
        cmp("lit_rebof13", 256'(vector_out[0]), 256'(13));

        // Wrap-around.
        drive(1'b1, 1'b1, 1'b0, 0, fill(32'h7FFF_FFFF));
        drive(1'b1, 1'b0, 1'b1, 0, fill(32'h0000_0002));
        idle(3);
        cmp("lit_wrap", 256'(vector_out[5]), 256'(32'h8000_0001));

        // Beat in stage 1 when tracing falls is dropped: 1 + (100 dropped) + 2 = 3.
        drive(1'b1, 1'b1, 1'b0, 0, fill(32'd1));
        drive(1'b1, 1'b0, 1'b0, 0, fill(32'd100), 1'b0);
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        tracing  = 1'b0;
        @(posedge clk);
        #1;
        tracing = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 0, fill(32'd2));
        idle(3);
        cmp("lit_drop3", 256'(vector_out[0]), 256'(3));

        // Chain 1 MAX.
        cfg(8'h08, MY_ID);
        v = fill(32'd11); v[0] = 32'(-7);
        drive(1'b1, 1'b1, 1'b0, 1, v);
        v[0] = 32'd3;
        drive(1'b1, 1'b0, 1'b0, 1, v);
        v[0] = 32'(-1);
        drive(1'b1, 1'b0, 1'b1, 1, v);
        idle(3);
        cmp("lit_max3", 256'(vector_out[0]), 256'(3));
        cmp("lit_max_chain", 256'(chainId_out), 256'(1));
        v[0] = 32'(-9);
        drive(1'b1, 1'b1, 1'b1, 1, v);
        idle(3);
        cmp("lit_max_single", 256'(vector_out[0]), 256'(32'hFFFF_FFF7));

        // All chains SUM, round-robin interleave.
        cfg(8'h55, MY_ID);
        for (int j = 0; j < 4; j++)
            for (int c = 0; c < NC; c++)
                drive(1'b1, j == 0, j == 3, c, fill(32'(c + 1)));
        idle(3);
        cmp("lit_ilv_chain3", 256'(vector_out[2]), 256'(16));
        cmp("lit_ilv_id", 256'(chainId_out), 256'(3));

        // Reset mid-frame, then foreign config id must not change the mode.
        cfg(8'h01, MY_ID);
        drive(1'b1, 1'b1, 1'b0, 0, fill(32'd10));
        drive(1'b1, 1'b0, 1'b0, 0, fill(32'd10));
        do_reset();
        cfg(8'h01, MY_ID);
        cfg(8'h00, 8'h02);
        drive(1'b1, 1'b0, 1'b1, 0, fill(32'd4));
        idle(3);
        cmp("lit_nobof4", 256'(vector_out[1]), 256'(4));
        drive(1'b1, 1'b1, 1'b0, 0, fill(32'd1));
        drive(1'b1, 1'b0, 1'b1, 0, fill(32'd1));
        idle(3);
        cmp("lit_after_rst2", 256'(vector_out[6]), 256'(2));

        // Randomized traffic under random mode words.
        for (int r = 0; r < 4; r++) begin
            cfg(8'($urandom), MY_ID);
            for (int k = 0; k < 250; k++) begin
                for (int l = 0; l < N; l++) begin
                    case ($urandom_range(0, 3))
                        0: v[l] = $urandom;
                        1: v[l] = 32'($urandom_range(0, 20)) - 32'd10;
                        2: v[l] = 32'h7FFF_FFFF;
                        default: v[l] = 32'h8000_0000;
                    endcase
                end
                drive($urandom_range(0, 9) < 8, $urandom_range(0, 3) == 0,
                      $urandom_range(0, 2) == 0, int'($urandom_range(0, NC - 1)), v);
            end
        end

        idle(5);
        cmp("queue_empty", 256'(q.size()), 256'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/frame_reducer.md
Name: frame_reducer

Overview:
- Stage directly downstream of inputBuffer.
- Consumes its per-beat stream (valid, bof, eof, chainId, N-lane vector) and applies a per-chain, firmware-selected operation.
  - Pass-through.
  - Element-wise frame sum.
  - Element-wise frame max.
- Emits one reduced vector per frame (or every beat in pass-through) to the downstream filter/trace stages.
- Holds one N-lane accumulator per chain, so interleaved chains reduce independently.

Parameters:
- N, 8, lanes per vector.
- DATA_WIDTH, 32, bits per lane; two's-complement signed.
- MAX_CHAINS, 4, number of chains; per-chain accumulators; must be <=4 (2-bit mode field per chain in 8-bit configData).
- INITIAL_FIRMWARE, 0, reset value of the 8-bit mode register.
- PERSONAL_CONFIG_ID, 1, configId value that selects this block.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- tracing  in  1  1 = process stream; 0 = configuration mode.
- configId  in  8  configuration target id.
- configData  in  8  mode word; bits [2c+1:2c] = mode of chain c.
- valid_in  in  1  beat valid (from inputBuffer valid_out).
- bof_in  in  1  first beat of frame.
- eof_in  in  1  last beat of frame.
- chainId_in  in  $clog2(MAX_CHAINS)  chain of this beat.
- vector_in  in  [DATA_WIDTH-1:0] x N  beat data.
- valid_out  out  1  result valid.
- eof_out  out  1  result closes a frame (always 1 for reduced results; copies eof_in in pass-through).
- chainId_out  out  $clog2(MAX_CHAINS)  chain of result.
- vector_out  out  [DATA_WIDTH-1:0] x N  result data.

Behaviour:
- Reset (async, rst=1):
  - valid_out=0, eof_out=0, chainId_out=0, vector_out=all 0.
  - All accumulators = 0.
  - Pipeline valids = 0.
  - mode register = INITIAL_FIRMWARE.
  - Reset mid-frame discards the partial accumulation; the next frame must start with bof.
- Modes: 0 = PASS, 1 = SUM, 2 = MAX, 3 = reserved (behaves as PASS).
- Pipeline: 2 stages; latency exactly 2 cycles from the input beat to its output beat. Throughput is 1 beat/cycle with no backpressure, matching inputBuffer.
  - Stage 1: register valid, bof, eof, chainId and vector when tracing=1; otherwise stage-1 valid=0.
  - Stage 2: read acc[chainId], compute next value, write acc, register outputs. Read and write happen in the same stage, so back-to-back beats on the same chain need no forwarding.
- Next-value rule per lane, base = bof ? identity-free start : acc:
  - SUM: next = bof ? v : acc+v. Modulo 2^DATA_WIDTH; wraps silently, no saturation.
  - MAX: next = bof ? v : signed max(acc,v).
  - PASS: acc not written.
- Output rule:
  - PASS: valid_out = stage-2 valid; vector_out = v; eof_out = eof.
  - SUM/MAX: valid_out = stage-2 valid & eof; vector_out = next; eof_out = 1.
  - Non-eof beats in SUM/MAX produce valid_out=0; vector_out holds its previous value.
- Boundary conditions:
  - bof & eof on the same beat (single-beat frame): result = v.
  - A beat without a preceding bof on its chain accumulates onto the existing acc (0 after reset).
  - A beat with bof while a frame is open on that chain: the old partial is discarded, with no output.
  - Chains are fully independent; interleaving at any pattern is legal.
- Configuration:
  - While tracing=0 and configId==PERSONAL_CONFIG_ID, mode ← configData, registered one cycle later.
  - While tracing=0, valid_out is forced to 0 on the next edge; accumulators are retained.
  - Beats already in stage 1 when tracing falls are dropped.
  - A mode change mid-frame is legal but the partial result is undefined until the next bof.

Decomposition:
- Package frame_reducer_pkg:
  - Mode enum: PASS, SUM, MAX, RSVD.
  - MODE_W=2.
  - Function mode_of(word, chain).
- Sub-module reduce_lane, combinational, instantiated N times: inputs mode, bof, acc, v; output next.
- Top holds the pipeline registers, accumulator array, mode register and output muxing.

Test Plan:
- Reset with INITIAL_FIRMWARE=0 → stream chain 0 vectors lane i = i+1 → identical vectors appear 2 cycles later, eof_out mirrors eof_in.
- Config 0x01 (chain0 SUM) → chain 0 frame of 3 beats, each lane = 5, bof on beat 1, eof on beat 3 → exactly one valid_out, 2 cycles after beat 3, lanes = 15; no other valid_out.
- Config 0x08 (chain1 MAX) → chain 1 beats lane0 = -7, 3, -1 → output lane0 = 3. Then a single-beat frame (bof&eof) lane0 = -9 → output -9.
- SUM wrap: lanes 0x7FFFFFFF then 0x00000002 in one frame → 0x80000001.
- Interleaved chains 0..3, all SUM (0x55), round-robin beats of value c+1, 4 beats per frame → outputs per chain = 4(c+1), with correct chainId_out.
- Assert rst mid-frame after 2 SUM beats of 10, then new frame 1,1 → output 2; valid_out=0 throughout reset; tracing=0 with configId≠PERSONAL_CONFIG_ID leaves the mode unchanged.
